// File: rtl/cam_pkg.sv
// State encoding, default timing and counter sizing shared by the camera bring-up sequencer.
package cam_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PWRUP     = 3'd1,
        ST_RSTREL    = 3'd2,
        ST_CFG_START = 3'd3,
        ST_CFG_WAIT  = 3'd4,
        ST_SKIP      = 3'd5,
        ST_RUN       = 3'd6,
        ST_ERROR     = 3'd7
    } cam_state_t;

    localparam int CAM_PWR_CYC_DEF          = 50_000;
    localparam int CAM_POST_RST_CYC_DEF     = 50_000;
    localparam int CAM_INIT_TIMEOUT_CYC_DEF = 5_000_000;
    localparam int CAM_SKIP_FRAMES_DEF      = 2;
    localparam int CAM_MAX_RETRY_DEF        = 3;
    localparam int CAM_WDOG_CYC_DEF         = 2_500_000;
    localparam int CAM_SKIP_W               = 4;

    // Width that holds the largest of the timed-state lengths.
    function automatic int cam_cnt_w(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return $clog2(m + 1);
    endfunction

    localparam int CAM_CNT_W = cam_cnt_w(CAM_PWR_CYC_DEF, CAM_POST_RST_CYC_DEF,
                                         CAM_INIT_TIMEOUT_CYC_DEF, CAM_WDOG_CYC_DEF);

endpackage

// File: rtl/sync_rise_det.sv
// Two-flop synchroniser for an asynchronous level plus a registered one-cycle rising-edge pulse.
module sync_rise_det (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_d,
    output logic o_rise
);

    logic [1:0] sync_q;
    logic       sync_d;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            sync_q <= 2'b00;
            sync_d <= 1'b0;
            o_rise <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], i_d};
            sync_d <= sync_q[1];
            o_rise <= sync_q[1] & ~sync_d;
        end
    end

endmodule

// File: rtl/cam_bringup_ctrl.sv
// Camera power-up sequencer: PWDN/RESET pins, cam_init handshake with retries, frame skip, capture enable.
// Build option CAM_WDOG_EN adds a RUN-state vsync watchdog that restarts the sequence.
module cam_bringup_ctrl
    import cam_pkg::*;
#(
    parameter int PWR_CYC          = CAM_PWR_CYC_DEF,
    parameter int POST_RST_CYC     = CAM_POST_RST_CYC_DEF,
    parameter int INIT_TIMEOUT_CYC = CAM_INIT_TIMEOUT_CYC_DEF,
    parameter int SKIP_FRAMES      = CAM_SKIP_FRAMES_DEF,
    parameter int MAX_RETRY        = CAM_MAX_RETRY_DEF,
    parameter int WDOG_CYC         = CAM_WDOG_CYC_DEF
) (
    input  logic       i_clk,
    input  logic       i_rstn,
    input  logic       i_start,
    input  logic       i_stop,
    output logic       o_cam_reset,
    output logic       o_cam_pwdn,
    output logic       o_init_rstn,
    output logic       o_init_start,
    input  logic       i_init_done,
    input  logic       i_vsync,
    output logic       o_capture_en,
    output logic       o_ready,
    output logic       o_error,
    output logic [1:0] o_retry_cnt,
    output logic       o_wdog_trip
);

    // state     | meaning
    // IDLE      | powered down, waiting for start      PWRUP    | pwdn released, sensor in reset
    // RSTREL    | reset released, settling             CFG_START| one-cycle cam_init kick
    // CFG_WAIT  | waiting for init done / timeout      SKIP     | discarding unstable frames
    // RUN       | capture enabled                      ERROR    | config retries exhausted

    localparam int CNT_W = cam_cnt_w(PWR_CYC, POST_RST_CYC, INIT_TIMEOUT_CYC, WDOG_CYC);
    localparam logic [CNT_W-1:0]      PWR_LAST  = CNT_W'(PWR_CYC - 1);
    localparam logic [CNT_W-1:0]      POST_LAST = CNT_W'(POST_RST_CYC - 1);
    localparam logic [CNT_W-1:0]      TO_LAST   = CNT_W'(INIT_TIMEOUT_CYC - 1);
    localparam logic [CAM_SKIP_W-1:0] SKIP_LAST = CAM_SKIP_W'(SKIP_FRAMES - 1);
    localparam logic [1:0]            RETRY_LIM = 2'(MAX_RETRY);
`ifdef CAM_WDOG_EN
    localparam logic [CNT_W-1:0]      WDOG_LAST = CNT_W'(WDOG_CYC - 1);
    logic wdog_hit;
`endif

    cam_state_t            state, state_nxt;
    logic [CNT_W-1:0]      cnt;
    logic [CAM_SKIP_W-1:0] skip_cnt, skip_nxt;
    logic [1:0]            retry_nxt;
    logic                  vsync_rise;
    logic                  cnt_inc, cnt_clr;
    logic                  powered;

    sync_rise_det u_vsync_sync (
        .i_clk  (i_clk),
        .i_rstn (i_rstn),
        .i_d    (i_vsync),
        .o_rise (vsync_rise)
    );

    always_comb begin
        state_nxt = state;
        retry_nxt = o_retry_cnt;
        skip_nxt  = skip_cnt;
        cnt_inc   = (state == ST_PWRUP) || (state == ST_RSTREL) || (state == ST_CFG_WAIT);
        cnt_clr   = 1'b0;
`ifdef CAM_WDOG_EN
        wdog_hit  = 1'b0;
        if (state == ST_RUN) begin
            cnt_inc = !vsync_rise;
            cnt_clr = vsync_rise;
        end
`endif
        if (i_stop) begin
            state_nxt = ST_IDLE;
            retry_nxt = 2'd0;
        end else begin
            unique case (state)
                ST_IDLE:      if (i_start) state_nxt = ST_PWRUP;
                ST_PWRUP:     if (cnt == PWR_LAST) state_nxt = ST_RSTREL;
                ST_RSTREL:    if (cnt == POST_LAST) state_nxt = ST_CFG_START;
                ST_CFG_START: state_nxt = ST_CFG_WAIT;
                ST_CFG_WAIT: begin
                    // done wins over a timeout landing on the same cycle
                    if (i_init_done) begin
                        state_nxt = ST_SKIP;
                    end else if (cnt == TO_LAST) begin
                        retry_nxt = o_retry_cnt + 2'd1;
                        state_nxt = (retry_nxt == RETRY_LIM) ? ST_ERROR : ST_PWRUP;
                    end
                end
                ST_SKIP: begin
                    if (vsync_rise) begin
                        if (skip_cnt == SKIP_LAST) state_nxt = ST_RUN;
                        else skip_nxt = skip_cnt + 4'd1;
                    end
                end
                ST_RUN: begin
`ifdef CAM_WDOG_EN
                    if (!vsync_rise && cnt == WDOG_LAST) begin
                        wdog_hit  = 1'b1;
                        state_nxt = ST_PWRUP;
                    end
`endif
                end
                ST_ERROR: begin
                    if (i_start) begin
                        retry_nxt = 2'd0;
                        state_nxt = ST_PWRUP;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    assign powered = state_nxt inside {ST_RSTREL, ST_CFG_START, ST_CFG_WAIT, ST_SKIP, ST_RUN};

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            skip_cnt     <= '0;
            o_retry_cnt  <= 2'd0;
            o_cam_pwdn   <= 1'b1;
            o_cam_reset  <= 1'b0;
            o_init_rstn  <= 1'b0;
            o_init_start <= 1'b0;
            o_capture_en <= 1'b0;
            o_ready      <= 1'b0;
            o_error      <= 1'b0;
        end else begin
            state       <= state_nxt;
            o_retry_cnt <= retry_nxt;
            skip_cnt    <= (state_nxt == ST_SKIP) ? skip_nxt : '0;
            if (state_nxt != state || cnt_clr) cnt <= '0;
            else if (cnt_inc) cnt <= cnt + CNT_W'(1);
            o_cam_pwdn   <= (state_nxt == ST_IDLE) || (state_nxt == ST_ERROR);
            o_cam_reset  <= powered;
            o_init_rstn  <= powered;
            o_init_start <= (state_nxt == ST_CFG_START);
            o_capture_en <= (state_nxt == ST_RUN);
            o_ready      <= (state_nxt == ST_RUN);
            o_error      <= (state_nxt == ST_ERROR);
        end
    end

`ifdef CAM_WDOG_EN
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) o_wdog_trip <= 1'b0;
        else         o_wdog_trip <= wdog_hit && !i_stop;
    end
`else
    assign o_wdog_trip = 1'b0;
`endif

endmodule

// File: tb/tb_cam_bringup_ctrl.sv
// Randomised bring-up scenarios against a timeline model of the camera sequencer.
module tb_cam_bringup_ctrl;

    localparam int PWR   = 4;
    localparam int POST  = 8;
    localparam int TO    = 100;
    localparam int SKIPF = 2;
    localparam int MAXR  = 3;
    localparam int WDOG  = 50;
    localparam int L     = PWR + POST + 1 + TO;
    localparam logic [9:0] RESET_OUTS = 10'b10_0000_0000;

    logic       clk, rstn, start, stop, init_done, vsync;
    logic       cam_reset, cam_pwdn, init_rstn, init_start, capture_en, ready, error, wdog_trip;
    logic [1:0] retry_cnt;
    logic [9:0] obs_outs;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // current scenario plan, all in absolute edge numbers
    int e_start, n_fail, s_skip, r_run, p_stop, t_end, t_noise;
    int v_rise[$];

    cam_bringup_ctrl #(
        .PWR_CYC(PWR), .POST_RST_CYC(POST), .INIT_TIMEOUT_CYC(TO),
        .SKIP_FRAMES(SKIPF), .MAX_RETRY(MAXR), .WDOG_CYC(WDOG)
    ) dut (
        .i_clk        (clk),
        .i_rstn       (rstn),
        .i_start      (start),
        .i_stop       (stop),
        .o_cam_reset  (cam_reset),
        .o_cam_pwdn   (cam_pwdn),
        .o_init_rstn  (init_rstn),
        .o_init_start (init_start),
        .i_init_done  (init_done),
        .i_vsync      (vsync),
        .o_capture_en (capture_en),
        .o_ready      (ready),
        .o_error      (error),
        .o_retry_cnt  (retry_cnt),
        .o_wdog_trip  (wdog_trip)
    );

    assign obs_outs = {cam_pwdn, cam_reset, init_rstn, init_start, capture_en,
                       ready, error, wdog_trip, retry_cnt};

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got pwdn/rst/irstn/istart/cap/rdy/err/trip/retry=%b expected %b",
                     tag, obs, exp);
        end
    endtask

    // Expected outputs after edge t, derived from the phase timeline of the current plan.
    function automatic logic [9:0] ref_outs(input int t);
        logic       pwdn    = 1'b1;
        logic       powered = 1'b0;
        logic       istart  = 1'b0;
        logic       run     = 1'b0;
        logic       err     = 1'b0;
        logic       trip    = 1'b0;
        logic [1:0] rc      = 2'd0;
        bit         wd_on;
        int         a, off;
`ifdef CAM_WDOG_EN
        wd_on = 1'b1;
`else
        wd_on = 1'b0;
`endif
        if (p_stop >= 0 && t >= p_stop) begin
            pwdn = 1'b1;
        end else if (n_fail == MAXR && t >= e_start + MAXR * L) begin
            err = 1'b1;
            rc  = 2'(MAXR);
        end else if (n_fail < MAXR && r_run >= 0 && t >= r_run) begin
            pwdn = 1'b0;
            rc   = 2'(n_fail);
            if (wd_on && t >= r_run + WDOG) begin
                trip = (t == r_run + WDOG);
            end else begin
                powered = 1'b1;
                run     = 1'b1;
            end
        end else if (n_fail < MAXR && t >= s_skip) begin
            pwdn    = 1'b0;
            powered = 1'b1;
            rc      = 2'(n_fail);
        end else begin
            a       = (t - e_start) / L;
            off     = (t - e_start) % L;
            pwdn    = 1'b0;
            rc      = 2'(a);
            powered = (off >= PWR);
            istart  = (off == PWR + POST);
        end
        return {pwdn, powered, powered, istart, run, run, err, trip, rc};
    endfunction

    // mode 0: stop after a short RUN dwell, 1: stop at a random early point,
    // 2: dwell past the watchdog period then stop, 3: stay in RUN, 4: stop during config wait
    task automatic plan(input int f, input int j, input int mode);
        int w, v, counted;
        e_start = cyc + 1;
        n_fail  = f;
        w       = e_start + f * L + PWR + POST + 1;
        s_skip  = (f < MAXR) ? w + j : 32'h3fff_ffff;
        r_run   = -1;
        p_stop  = -1;
        v_rise.delete();
        t_noise = e_start + 1 + $urandom_range(0, PWR + POST - 2);
        if (f == MAXR) begin
            t_end = e_start + MAXR * L + 3;
            if (mode == 1) begin
                p_stop = e_start + 2 + $urandom_range(0, MAXR * L - 3);
                t_end  = p_stop + 2;
            end
        end else if (mode == 1) begin
            p_stop = e_start + 2 + $urandom_range(0, s_skip - e_start - 3);
            t_end  = p_stop + 2;
        end else if (mode == 4) begin
            p_stop = w + $urandom_range(0, j - 1);
            t_end  = p_stop + 2;
        end else begin
            v = s_skip - 5 + $urandom_range(0, 10);
            counted = 0;
            while (counted < SKIPF) begin
                v_rise.push_back(v);
                if (v + 3 > s_skip) begin
                    counted++;
                    if (counted == SKIPF) r_run = v + 3;
                end
                v = v + $urandom_range(4, 12);
            end
            if (mode == 0) p_stop = r_run + $urandom_range(3, 30);
            else if (mode == 2) p_stop = r_run + WDOG + 3;
            t_end = (p_stop >= 0) ? p_stop + 2 : r_run + 5;
        end
    endtask

    task automatic drive(input int t);
        start     = (t == e_start) || (t == t_noise && (p_stop < 0 || t < p_stop));
        stop      = (t == p_stop);
        init_done = (t >= s_skip) && (p_stop < 0 || t <= p_stop);
        vsync     = 1'b0;
        foreach (v_rise[k])
            if (t == v_rise[k] || t == v_rise[k] + 1) vsync = 1'b1;
    endtask

    task automatic run_iter(input int f, input int j, input int mode);
        int t;
        plan(f, j, mode);
        drive(e_start);
        while (1) begin
            @(negedge clk);
            t = cyc;
            check($sformatf("outs f=%0d m=%0d rel=%0d", f, mode, t - e_start), obs_outs, ref_outs(t));
            if (t >= t_end) break;
            drive(t + 1);
        end
    endtask

    initial begin
        #400_000;
        $display("FAIL global_timeout: got no finish by cycle %0d expected finish", cyc);
        $fatal(1, "bench time limit reached");
    end

    initial begin
        int m;
        rstn = 1'b0; start = 1'b0; stop = 1'b0; init_done = 1'b0; vsync = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outs", obs_outs, RESET_OUTS);
        rstn = 1'b1;
        @(negedge clk);
        check("idle_after_reset", obs_outs, RESET_OUTS);

        run_iter(0, TO, 0);
        run_iter(MAXR, 1, 0);
        run_iter(1, 7, 0);
        run_iter(0, TO, 4);

        start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        check("start_stop_idle", obs_outs, RESET_OUTS);
        @(negedge clk);
        check("start_stop_idle_hold", obs_outs, RESET_OUTS);

        for (int i = 0; i < 8; i++) begin
            case ($urandom_range(0, 2))
                0:       m = 0;
                1:       m = 1;
                default: m = 4;
            endcase
            run_iter($urandom_range(0, MAXR), $urandom_range(1, TO), m);
        end

        run_iter(1, 10, 2);

        run_iter(0, 20, 3);
        #2 rstn = 1'b0;
        #1 check("async_reset_immediate", obs_outs, RESET_OUTS);
        init_done = 1'b0; vsync = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("held_in_reset", obs_outs, RESET_OUTS);
        rstn = 1'b1;
        @(negedge clk);
        check("idle_after_release", obs_outs, RESET_OUTS);
        run_iter($urandom_range(0, MAXR - 1), $urandom_range(1, TO), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
